// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Purpose  : Pong-style score keeper with hit debounce holdoff, saturating
//            score, high-score tracking and a registered display value.
// Revision : 1.0
// ============================================================================
module score_keeper #(
    parameter int HOLDOFF_CYCLES = 16,
    parameter int MAX_SCORE      = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    input  logic       show_high,
    output logic [9:0] Score_Counter,
    output logic [7:0] high_score,
    output logic       playing,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [7:0]  c_MAX_SCORE = 8'(MAX_SCORE);
    localparam logic [15:0] c_HOLDOFF   = 16'(HOLDOFF_CYCLES);

    state_t      state_q;
    logic [7:0]  score_q;
    logic [7:0]  score_d;
    logic [7:0]  high_q;
    logic [15:0] holdoff_q;
    logic        hit_q;
    logic [9:0]  disp_q;
    logic        rise;

    assign rise    = hit & ~hit_q;
    assign score_d = (score_q >= c_MAX_SCORE) ? score_q : score_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            score_q   <= 8'd0;
            high_q    <= 8'd0;
            holdoff_q <= 16'd0;
            hit_q     <= 1'b0;
            disp_q    <= 10'd0;
        end else begin
            hit_q <= hit;
            // Holdoff runs down in every state; later assignments below override it.
            if (holdoff_q != 16'd0) begin
                holdoff_q <= holdoff_q - 16'd1;
            end
            case (state_q)
                IDLE, OVER: begin
                    if (start) begin
                        state_q   <= PLAY;
                        score_q   <= 8'd0;
                        holdoff_q <= 16'd0;
                    end
                end
                PLAY: begin
                    // Miss has priority over a coincident hit.
                    if (miss) begin
                        state_q <= OVER;
                        if (score_q > high_q) begin
                            high_q <= score_q;
                        end
                    end else if (rise && (holdoff_q == 16'd0)) begin
                        score_q   <= score_d;
                        holdoff_q <= c_HOLDOFF;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            disp_q <= {2'b00, (show_high ? high_q : score_q)};
        end
    end

    assign Score_Counter = disp_q;
    assign high_score    = high_q;
    assign playing       = (state_q == PLAY);
    assign game_over     = (state_q == OVER);

endmodule
`default_nettype wire

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter HOLDOFF_CYCLES, default 16: cycles after a counted hit during which further hit edges are ignored (1..65535).
REQ-002 Parameter MAX_SCORE, default 255: saturation ceiling of the score (1..255).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  level, sampled each cycle; requests a new game.
REQ-006 hit  input  1  level from paddle/ball collision detect; may stay high for many cycles.
REQ-007 miss  input  1  level; ball passed the paddle.
REQ-008 show_high  input  1  0 = display current score, 1 = display high score.
REQ-009 Score_Counter  output  10  registered display value for the score display stage; bits [9:8] always 0.
REQ-010 high_score  output  8  registered best score since reset.
REQ-011 playing  output  1  high while in state PLAY.
REQ-012 game_over  output  1  high while in state OVER.

Function
REQ-013 States: IDLE, PLAY, OVER; playing and game_over decode directly from the state register.
REQ-014 IDLE: start=1 -> PLAY; score cleared to 0 and holdoff cleared to 0 on the same edge.
REQ-015 PLAY: miss=1 -> OVER; start is ignored.
REQ-016 OVER: start=1 -> PLAY; score cleared to 0 and holdoff cleared to 0 on the same edge; high_score is kept.
REQ-017 hit_q registers hit every cycle in every state; rise = hit & ~hit_q.
REQ-018 In PLAY with rise=1, holdoff=0, miss=0: score <= min(score+1, MAX_SCORE); holdoff loads HOLDOFF_CYCLES on the same edge.
REQ-019 A rise with holdoff!=0 is discarded, not deferred; holding hit high never produces a second count.
REQ-020 holdoff decrements by 1 each cycle while nonzero, in any state; it never wraps below 0.
REQ-021 Score at MAX_SCORE: further counted hits leave score unchanged, but holdoff still reloads.
REQ-022 Simultaneous hit rise and miss in PLAY: miss wins; the hit is not counted; transition to OVER.
REQ-023 On the PLAY->OVER edge: if score > high_score then high_score <= score; ties leave high_score unchanged.
REQ-024 Score_Counter <= {2'b00, show_high ? high_score : score} every cycle; one-cycle latency from score, high_score, or show_high changes.
REQ-025 Hit-to-display latency: score updates on the edge that samples the rise; Score_Counter reflects it one edge later.
REQ-026 Score_Counter never exceeds MAX_SCORE, so the downstream 8-bit binary-to-BCD stage never sees an out-of-range value.
REQ-027 hit and miss are ignored in IDLE and OVER; score stays frozen in OVER.

Reset
REQ-028 rst=0 sampled at a clock edge: state=IDLE, score=0, high_score=0, holdoff=0, hit_q=0, Score_Counter=0, playing=0, game_over=0.
REQ-029 Reset takes priority over every other input, including mid-game and mid-holdoff; after reset, high_score is lost.
REQ-030 No output changes without a clock edge; reset is not asynchronous.

Verification
REQ-031 Reset, start pulse, three 1-cycle hit pulses spaced 20 cycles apart -> Score_Counter=3 one cycle after the third counted edge; playing=1.
REQ-032 HOLDOFF_CYCLES=16; hit held high 50 cycles -> exactly +1. Second rise 5 cycles after the counted hit -> ignored. Rise 17 cycles after -> counted.
REQ-033 MAX_SCORE=255; 260 spaced hits -> Score_Counter stays 255; no wrap to 0.
REQ-034 Game 1 score 7 then miss -> game_over=1, high_score=7. Game 2 score 4 then miss -> high_score=7. show_high=1 -> Score_Counter=7 one cycle later.
REQ-035 hit rise and miss in the same cycle at score 2 -> OVER with score 2, high_score=2.
REQ-036 rst=0 asserted mid-PLAY at score 9 during holdoff -> next edge all outputs 0 and state IDLE. Hits in IDLE -> no count.
